pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core pipeline registers: pc, if_id, id_ex, ex_mem and mem_wb.
- Generates a write-enable (hold) and a flush (bubble insert) per pipeline register.
- Sources handled: load-use hazards, EX branch/jump redirect, the multi-cycle mul/div unit, and a memory ready handshake with a timeout.
- Sits beside the datapath; its outputs drive the wen/flush inputs of the stage register blocks.

Parameters:
MEM_TIMEOUT, 255, cycles in MEM_WAIT before abort; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; MEM_TIMEOUT must be < 2^CNT_W.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset; asynchronous, active-high
id_rs1_idx  in  `REG_IDX_WIDTH  ID source 1 index
id_rs1_ren  in  1  ID reads rs1
id_rs2_idx  in  `REG_IDX_WIDTH  ID source 2 index
id_rs2_ren  in  1  ID reads rs2
ex_rd_idx  in  `REG_IDX_WIDTH  destination of the instruction in EX
ex_is_load  in  1  instruction in EX is a load
ex_redirect_i  in  1  EX resolved a taken branch or jump
ex_md_start_i  in  1  EX issues a mul/div operation (single-cycle pulse)
ex_md_done_i  in  1  mul/div result valid this cycle
mem_req_i  in  1  instruction in MEM needs the data bus
mem_ready_i  in  1  data bus completes this cycle
pc_wen_o, if_id_wen_o, id_ex_wen_o, ex_mem_wen_o, mem_wb_wen_o  out  1 each  register update enables
if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each  load a bubble (reset value) instead of input data
mem_timeout_o  out  1  one-cycle pulse when a memory access is aborted

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
  - While rst=1: state=RUN, timeout counter=0, all *_wen_o=0, all *_flush_o=0, mem_timeout_o=0.
  - First cycle after release: normal RUN decode.
- Output timing: outputs are combinational from the registered state and current inputs, giving zero-latency stall. State and counter update on the rising clk edge.
- States: RUN, MD_BUSY, MEM_WAIT. Priority per cycle, highest first: memory stall > mul/div busy > redirect > load-use.
- Memory stall (mem_req_i=1 & mem_ready_i=0 in RUN, or any cycle in MEM_WAIT without ready):
  - All wen=0; no flushes.
  - RUN->MEM_WAIT; counter cleared on entry, then incremented each MEM_WAIT cycle.
  - mem_ready_i=1 ends the stall: all wen=1 that cycle; MEM_WAIT->RUN.
  - Zero-wait access (req & ready in RUN) causes no stall.
- Timeout: in MEM_WAIT, if counter==MEM_TIMEOUT-1 and mem_ready_i=0:
  - mem_timeout_o=1 for one cycle.
  - ex_mem_wen_o=1, mem_wb_flush_o=1, mem_wb_wen_o=1; pc, if_id and id_ex hold.
  - MEM_WAIT->RUN.
  - If ready and timeout coincide, ready wins and there is no pulse.
- Mul/div (ex_md_start_i=1 in RUN without ex_md_done_i, or in MD_BUSY without done):
  - pc/if_id/id_ex wen=0; ex_mem_flush_o=1 with ex_mem_wen_o=1; mem_wb_wen_o=1.
  - RUN->MD_BUSY.
  - ex_md_done_i=1: release, all wen=1; state->RUN.
  - Start and done in the same cycle cause no stall.
- Redirect (RUN, no higher-priority event):
  - All wen=1; if_id_flush_o=1 and id_ex_flush_o=1.
  - ex_redirect_i is ignored while frozen; EX holds the instruction and reasserts it.
- Load-use: condition is ex_is_load & ex_rd_idx!=0 & ((id_rs1_ren & id_rs1_idx==ex_rd_idx) | (id_rs2_ren & id_rs2_idx==ex_rd_idx)).
  - pc/if_id wen=0; id_ex_flush_o=1 with id_ex_wen_o=1; ex_mem and mem_wb wen=1.
  - Suppressed when redirect is asserted the same cycle.
- Default RUN: all wen=1, all flush=0.
- Invariant: a flush is never asserted with its matching wen=0.
- Illegal state encodings return to RUN.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds output perf_stall_cnt_o [31:0], counting cycles with pc_wen_o=0 outside reset. It saturates at 32'hFFFF_FFFF and is cleared by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- defines.v gains `PCTRL_ST_WIDTH (2) and state codes `PCTRL_RUN=0, `PCTRL_MD_BUSY=1, `PCTRL_MEM_WAIT=2. It reuses `REG_IDX_WIDTH and `ENABLE.
- State and counter registers use the existing dff cell.
- No further sub-module; the hazard compare stays inline.

Test Plan:
- Reset: rst=1 mid-MEM_WAIT -> all wen=0, no flushes; after release with idle inputs -> all wen=1, state RUN.
- Load-use: ex_is_load=1, ex_rd_idx=5, id_rs2_ren=1, id_rs2_idx=5 -> pc/if_id wen=0, id_ex_flush=1 for 1 cycle. Same with ex_rd_idx=0 -> no stall.
- Redirect plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_wen=1, no hold.
- Mul/div: start at cycle 0, done at cycle 33 -> pc/if_id/id_ex held for 33 cycles (cycles 0-32) with ex_mem_flush=1 each; cycle 33 all wen=1.
- Memory: req with ready after 3 cycles -> all wen=0 for 3 cycles, released on the ready cycle. Req+ready in the same cycle -> no stall.
- Timeout: MEM_TIMEOUT=4, req held, never ready -> mem_timeout_o pulses in MEM_WAIT cycle 4 with mem_wb_flush=1, then RUN. Ready in that cycle -> no pulse.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: register-index width,
// state codes and the state/enable/flush types used by the controller.
`ifndef PIPE_CTRL_DEFINES_SV
`define PIPE_CTRL_DEFINES_SV
`define REG_IDX_WIDTH  5
`define ENABLE         1'b1
`define PCTRL_ST_WIDTH 2
`define PCTRL_RUN      2'd0
`define PCTRL_MD_BUSY  2'd1
`define PCTRL_MEM_WAIT 2'd2
`endif

package pipe_ctrl_pkg;

   typedef enum logic [`PCTRL_ST_WIDTH-1:0] {
      ST_RUN      = `PCTRL_RUN,
      ST_MD_BUSY  = `PCTRL_MD_BUSY,
      ST_MEM_WAIT = `PCTRL_MEM_WAIT
   } pctrl_state_e;

   typedef struct packed {
      logic pc;
      logic if_id;
      logic id_ex;
      logic ex_mem;
      logic mem_wb;
   } pctrl_wen_t;

   typedef struct packed {
      logic if_id;
      logic id_ex;
      logic ex_mem;
      logic mem_wb;
   } pctrl_flush_t;

   localparam pctrl_wen_t   WEN_ALL   = '{default: `ENABLE};
   localparam pctrl_flush_t FLUSH_NONE = '{default: 1'b0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and per-stage wen/flush outputs of the pipeline controller.
// Optional perf_stall_cnt_o exists only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
   logic [`REG_IDX_WIDTH-1:0] id_rs1_idx;
   logic                      id_rs1_ren;
   logic [`REG_IDX_WIDTH-1:0] id_rs2_idx;
   logic                      id_rs2_ren;
   logic [`REG_IDX_WIDTH-1:0] ex_rd_idx;
   logic                      ex_is_load;
   logic                      ex_redirect_i;
   logic                      ex_md_start_i;
   logic                      ex_md_done_i;
   logic                      mem_req_i;
   logic                      mem_ready_i;

   logic pc_wen_o;
   logic if_id_wen_o;
   logic id_ex_wen_o;
   logic ex_mem_wen_o;
   logic mem_wb_wen_o;
   logic if_id_flush_o;
   logic id_ex_flush_o;
   logic ex_mem_flush_o;
   logic mem_wb_flush_o;
   logic mem_timeout_o;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cnt_o;
`endif

   modport master (
      output id_rs1_idx, id_rs1_ren, id_rs2_idx, id_rs2_ren, ex_rd_idx, ex_is_load,
             ex_redirect_i, ex_md_start_i, ex_md_done_i, mem_req_i, mem_ready_i,
      input  pc_wen_o, if_id_wen_o, id_ex_wen_o, ex_mem_wen_o, mem_wb_wen_o,
             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o, mem_timeout_o
`ifdef PIPE_CTRL_PERF_EN
      , input perf_stall_cnt_o
`endif
   );

   modport slave (
      input  id_rs1_idx, id_rs1_ren, id_rs2_idx, id_rs2_ren, ex_rd_idx, ex_is_load,
             ex_redirect_i, ex_md_start_i, ex_md_done_i, mem_req_i, mem_ready_i,
      output pc_wen_o, if_id_wen_o, id_ex_wen_o, ex_mem_wen_o, mem_wb_wen_o,
             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o, mem_timeout_o
`ifdef PIPE_CTRL_PERF_EN
      , output perf_stall_cnt_o
`endif
   );
endinterface

// File: rtl/pipe_ctrl_dff.sv
// Plain register cell with asynchronous active-high reset to a parameterised value.
module pipe_ctrl_dff #(
   parameter int unsigned      W       = 1,
   parameter logic [W-1:0]     RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= RST_VAL;
      else     q <= d;
   end
endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the pc, if_id, id_ex, ex_mem and mem_wb registers.
// Define PIPE_CTRL_PERF_EN to add the saturating stall-cycle counter perf_stall_cnt_o.
//
// state       | meaning
// ST_RUN      | normal issue; decode memory stall, mul/div start, redirect, load-use
// ST_MD_BUSY  | mul/div in flight; front end held, bubbles fed to ex_mem
// ST_MEM_WAIT | data bus access pending; whole pipe frozen until ready or timeout
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic         clk,
   input  logic         rst,
   pipe_ctrl_if.slave   bus
);

   localparam bit               TO_EN   = (MEM_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   pctrl_state_e                state_d;
   logic [`PCTRL_ST_WIDTH-1:0]  state_q;
   logic [CNT_W-1:0]            cnt_d;
   logic [CNT_W-1:0]            cnt_q;

   pctrl_wen_t   wen;
   pctrl_flush_t flush;
   logic         timeout;
   logic         load_use;
   logic         md_hold;

   pipe_ctrl_dff #(.W(`PCTRL_ST_WIDTH), .RST_VAL(`PCTRL_RUN)) u_state_reg (
      .clk (clk),
      .rst (rst),
      .d   (state_d),
      .q   (state_q)
   );

   pipe_ctrl_dff #(.W(CNT_W), .RST_VAL('0)) u_cnt_reg (
      .clk (clk),
      .rst (rst),
      .d   (cnt_d),
      .q   (cnt_q)
   );

   always_comb begin
      load_use = bus.ex_is_load && (bus.ex_rd_idx != '0) &&
                 ((bus.id_rs1_ren && (bus.id_rs1_idx == bus.ex_rd_idx)) ||
                  (bus.id_rs2_ren && (bus.id_rs2_idx == bus.ex_rd_idx)));
   end

   always_comb begin
      state_d = ST_RUN;
      cnt_d   = cnt_q;
      wen     = WEN_ALL;
      flush   = FLUSH_NONE;
      timeout = 1'b0;
      md_hold = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (bus.mem_req_i && !bus.mem_ready_i) begin
               wen     = '0;
               cnt_d   = '0;
               state_d = ST_MEM_WAIT;
            end else if (bus.ex_md_start_i && !bus.ex_md_done_i) begin
               md_hold = 1'b1;
               state_d = ST_MD_BUSY;
            end else if (bus.ex_redirect_i) begin
               flush.if_id = 1'b1;
               flush.id_ex = 1'b1;
            end else if (load_use) begin
               wen.pc      = 1'b0;
               wen.if_id   = 1'b0;
               flush.id_ex = 1'b1;
            end
         end
         ST_MD_BUSY: begin
            if (!bus.ex_md_done_i) begin
               md_hold = 1'b1;
               state_d = ST_MD_BUSY;
            end
         end
         ST_MEM_WAIT: begin
            if (bus.mem_ready_i) begin
               state_d = ST_RUN;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               // Abort: retire a bubble into WB and let the bubble in EX advance.
               wen.pc       = 1'b0;
               wen.if_id    = 1'b0;
               wen.id_ex    = 1'b0;
               flush.mem_wb = 1'b1;
               timeout      = 1'b1;
            end else begin
               wen     = '0;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = ST_MEM_WAIT;
            end
         end
         default: state_d = ST_RUN;
      endcase

      if (md_hold) begin
         wen.pc        = 1'b0;
         wen.if_id     = 1'b0;
         wen.id_ex     = 1'b0;
         flush.ex_mem  = 1'b1;
      end

      if (rst) begin
         wen     = '0;
         flush   = FLUSH_NONE;
         timeout = 1'b0;
      end
   end

   assign bus.pc_wen_o       = wen.pc;
   assign bus.if_id_wen_o    = wen.if_id;
   assign bus.id_ex_wen_o    = wen.id_ex;
   assign bus.ex_mem_wen_o   = wen.ex_mem;
   assign bus.mem_wb_wen_o   = wen.mem_wb;
   assign bus.if_id_flush_o  = flush.if_id;
   assign bus.id_ex_flush_o  = flush.id_ex;
   assign bus.ex_mem_flush_o = flush.ex_mem;
   assign bus.mem_wb_flush_o = flush.mem_wb;
   assign bus.mem_timeout_o  = timeout;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_cnt_d;
   logic [31:0] perf_cnt_q;

   always_comb begin
      perf_cnt_d = perf_cnt_q;
      if (!wen.pc && (perf_cnt_q != 32'hFFFF_FFFF)) perf_cnt_d = perf_cnt_q + 32'd1;
   end

   pipe_ctrl_dff #(.W(32), .RST_VAL('0)) u_perf_reg (
      .clk (clk),
      .rst (rst),
      .d   (perf_cnt_d),
      .q   (perf_cnt_q)
   );

   assign bus.perf_stall_cnt_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a rule-level model of the sequencer.
module tb_pipe_ctrl;

   localparam int unsigned MT = 4;

   // {pc,if_id,id_ex,ex_mem,mem_wb wen | if_id,id_ex,ex_mem,mem_wb flush | timeout}
   localparam logic [9:0] ALL_V   = 10'b11111_0000_0;
   localparam logic [9:0] STALL_V = 10'b00000_0000_0;
   localparam logic [9:0] MD_V    = 10'b00011_0010_0;
   localparam logic [9:0] REDIR_V = 10'b11111_1100_0;
   localparam logic [9:0] LU_V    = 10'b00111_0100_0;
   localparam logic [9:0] TO_V    = 10'b00011_0001_1;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   pipe_ctrl_if bus ();

   pipe_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] act_vec();
      return {bus.pc_wen_o, bus.if_id_wen_o, bus.id_ex_wen_o, bus.ex_mem_wen_o, bus.mem_wb_wen_o,
              bus.if_id_flush_o, bus.id_ex_flush_o, bus.ex_mem_flush_o, bus.mem_wb_flush_o,
              bus.mem_timeout_o};
   endfunction

   function automatic logic lu_hit();
      return bus.ex_is_load && (bus.ex_rd_idx != 5'd0) &&
             ((bus.id_rs1_ren && bus.id_rs1_idx == bus.ex_rd_idx) ||
              (bus.id_rs2_ren && bus.id_rs2_idx == bus.ex_rd_idx));
   endfunction

   // Model: which kind of freeze is in progress and how many stalled cycles it has seen.
   bit      m_md      = 1'b0;
   bit      m_wait    = 1'b0;
   int      m_waited  = 0;
   longint  m_stalls  = 0;

   always @(negedge clk) begin
      logic [9:0] exp_v;
      logic [9:0] got_v;
      got_v = act_vec();
      if (rst) begin
         exp_v    = STALL_V;
         m_md     = 1'b0;
         m_wait   = 1'b0;
         m_waited = 0;
         m_stalls = 0;
      end else if (m_wait) begin
         if (bus.mem_ready_i) begin
            exp_v  = ALL_V;
            m_wait = 1'b0;
         end else if (MT != 0 && m_waited == MT) begin
            exp_v  = TO_V;
            m_wait = 1'b0;
         end else begin
            exp_v    = STALL_V;
            m_waited = m_waited + 1;
         end
      end else if (m_md) begin
         if (bus.ex_md_done_i) begin
            exp_v = ALL_V;
            m_md  = 1'b0;
         end else begin
            exp_v = MD_V;
         end
      end else if (bus.mem_req_i && !bus.mem_ready_i) begin
         exp_v    = STALL_V;
         m_wait   = 1'b1;
         m_waited = 1;
      end else if (bus.ex_md_start_i && !bus.ex_md_done_i) begin
         exp_v = MD_V;
         m_md  = 1'b1;
      end else if (bus.ex_redirect_i) begin
         exp_v = REDIR_V;
      end else if (lu_hit()) begin
         exp_v = LU_V;
      end else begin
         exp_v = ALL_V;
      end
      checks++;
      if (got_v !== exp_v) begin
         failures++;
         $display("FAIL model t=%0t: outputs got %b expected %b", $time, got_v, exp_v);
      end
`ifdef PIPE_CTRL_PERF_EN
      checks++;
      if (bus.perf_stall_cnt_o !== 32'(m_stalls)) begin
         failures++;
         $display("FAIL perf_cnt t=%0t: got %0d expected %0d", $time, bus.perf_stall_cnt_o, m_stalls);
      end
      if (!rst && !exp_v[9]) m_stalls++;
`endif
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_rs1_idx    = 5'd0;
      bus.id_rs1_ren    = 1'b0;
      bus.id_rs2_idx    = 5'd0;
      bus.id_rs2_ren    = 1'b0;
      bus.ex_rd_idx     = 5'd0;
      bus.ex_is_load    = 1'b0;
      bus.ex_redirect_i = 1'b0;
      bus.ex_md_start_i = 1'b0;
      bus.ex_md_done_i  = 1'b0;
      bus.mem_req_i     = 1'b0;
      bus.mem_ready_i   = 1'b0;
   endtask

   task automatic lit(input string name, input logic [9:0] exp_v);
      logic [9:0] got_v;
      #2;
      got_v = act_vec();
      checks++;
      if (got_v !== exp_v) begin
         failures++;
         $display("FAIL %s: outputs got %b expected %b", name, got_v, exp_v);
      end
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset while frozen in MEM_WAIT, then idle release
      bus.mem_req_i = 1'b1;
      lit("mem_enter", STALL_V);
      next_cycle();
      lit("mem_wait", STALL_V);
      next_cycle();
      rst = 1'b1;
      lit("rst_mid_wait", STALL_V);
      next_cycle();
      rst = 1'b0;
      idle();
      lit("post_rst_idle", ALL_V);

      // load-use
      next_cycle();
      bus.ex_is_load = 1'b1; bus.ex_rd_idx = 5'd5; bus.id_rs2_ren = 1'b1; bus.id_rs2_idx = 5'd5;
      lit("lu_rs2", LU_V);
      next_cycle();
      bus.ex_rd_idx = 5'd0; bus.id_rs2_idx = 5'd0;
      lit("lu_rd_zero", ALL_V);
      next_cycle();
      bus.ex_rd_idx = 5'd5; bus.id_rs2_idx = 5'd5; bus.ex_redirect_i = 1'b1;
      lit("redir_over_lu", REDIR_V);
      next_cycle();
      idle();
      bus.ex_is_load = 1'b1; bus.ex_rd_idx = 5'd7; bus.id_rs1_ren = 1'b1; bus.id_rs1_idx = 5'd7;
      lit("lu_rs1", LU_V);
      next_cycle();
      bus.id_rs1_ren = 1'b0;
      lit("lu_no_ren", ALL_V);

      // mul/div: start at cycle 0, done at cycle 33
      next_cycle();
      idle();
      bus.ex_md_start_i = 1'b1;
      lit("md_c0", MD_V);
      for (int c = 1; c < 33; c++) begin
         next_cycle();
         bus.ex_md_start_i = 1'b0;
         lit("md_busy", MD_V);
      end
      next_cycle();
      bus.ex_md_done_i = 1'b1;
      lit("md_done", ALL_V);
      next_cycle();
      bus.ex_md_done_i = 1'b0;
      lit("md_after", ALL_V);
      next_cycle();
      bus.ex_md_start_i = 1'b1; bus.ex_md_done_i = 1'b1;
      lit("md_same_cycle", ALL_V);
      next_cycle();
      idle();
      lit("md_same_after", ALL_V);

      // memory wait of 3 cycles, then zero-wait access
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         bus.mem_req_i = 1'b1;
         lit("mem_stall", STALL_V);
      end
      next_cycle();
      bus.mem_ready_i = 1'b1;
      lit("mem_release", ALL_V);
      next_cycle();
      lit("mem_zero_wait", ALL_V);
      next_cycle();
      idle();
      lit("mem_idle", ALL_V);

      // timeout after MT waiting cycles, then ready coinciding with the timeout slot
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         bus.mem_req_i = 1'b1;
         lit("to_stall", STALL_V);
      end
      next_cycle();
      lit("to_pulse", TO_V);
      next_cycle();
      idle();
      lit("to_back_run", ALL_V);
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         bus.mem_req_i = 1'b1;
         lit("to_ready_stall", STALL_V);
      end
      next_cycle();
      bus.mem_ready_i = 1'b1;
      lit("to_ready_wins", ALL_V);
      next_cycle();
      idle();
      lit("to_ready_after", ALL_V);

      // randomized traffic, checked by the model process
      for (int i = 0; i < 4000; i++) begin
         next_cycle();
         rst               = ($urandom_range(0, 249) == 0);
         bus.id_rs1_idx    = 5'($urandom_range(0, 3));
         bus.id_rs1_ren    = ($urandom_range(0, 1) == 0);
         bus.id_rs2_idx    = 5'($urandom_range(0, 3));
         bus.id_rs2_ren    = ($urandom_range(0, 1) == 0);
         bus.ex_rd_idx     = 5'($urandom_range(0, 3));
         bus.ex_is_load    = ($urandom_range(0, 2) == 0);
         bus.ex_redirect_i = ($urandom_range(0, 7) == 0);
         bus.ex_md_start_i = ($urandom_range(0, 15) == 0);
         bus.ex_md_done_i  = ($urandom_range(0, 7) == 0);
         bus.mem_req_i     = ($urandom_range(0, 3) == 0);
         bus.mem_ready_i   = ($urandom_range(0, 3) == 0);
      end
      next_cycle();
      rst = 1'b0;
      idle();
      repeat (3) next_cycle();
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
